reg_file_mp: RTL



---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_clr_seq.sv | 64 ++++++
 rtl/reg_file_mp.sv | 92 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned PW_DEF = 2;
  localparam int unsigned NR_DEF = 3;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry once, one per cycle, after clr_req.
// Owns the IDLE/CLEAR state and the entry counter. It drives the clear
// write port of the storage array.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [PW-1:0] clr_addr
);

  clr_state_t    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;

  // Next-state: start on request in IDLE, step the counter, leave after the last entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status and clear-port outputs decoded from state and counter
  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = (state_q == CLEAR) && (cnt_q == '1);
    clr_we   = (state_q == CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with a per-entry written scoreboard and a
// sequenced clear. It has combinational reads and one write port.
// Optional macro REG_FILE_BYPASS_EN forwards an IDLE write to matching
// read ports in the same cycle.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned NR = NR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [DW-1:0]    dat_in,
  output logic             wr_drop,
  input  logic [NR*PW-1:0] rd_addr,
  output logic [NR*DW-1:0] dat_out,
  output logic [NR-1:0]    rd_valid
);

  localparam int unsigned DEPTH = 2 ** PW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic          clr_we;
  logic [PW-1:0] clr_addr;

  reg_file_clr_seq #(
    .PW (PW)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Write arbitration: the clear walk owns the array; user writes are dropped while it runs
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (clr_we) begin
      mem_d[clr_addr]   = '0;
      valid_d[clr_addr] = 1'b0;
    end else if (wr_en) begin
      mem_d[wr_addr]   = dat_in;
      valid_d[wr_addr] = 1'b1;
    end
  end

  // A user write attempted during the clear walk is flagged and discarded
  always_comb begin
    wr_drop = clr_busy && wr_en;
  end

  // Storage and scoreboard, zeroed immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  // Read muxes, one per port, with optional same-cycle write forwarding
  always_comb begin
    dat_out  = '0;
    rd_valid = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      dat_out[i*DW +: DW] = mem_q[rd_addr[i*PW +: PW]];
      rd_valid[i]         = valid_q[rd_addr[i*PW +: PW]];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && !clr_busy && (rd_addr[i*PW +: PW] == wr_addr)) begin
        dat_out[i*DW +: DW] = dat_in;
        rd_valid[i]         = 1'b1;
      end
`endif
    end
  end

endmodule
